// File: rtl/pwm_pkg.sv
// Shared definitions for the flash-backed PWM sample sequencer:
// FSM states, the SPI read opcode and the default timing parameters.
package pwm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_FETCH,
        ST_WAIT,
        ST_GAP
    } state_e;

    localparam logic [7:0] READ_OPCODE           = 8'h03;
    localparam int         DEFAULT_SAMPLE_PERIOD = 256;
    localparam int         DEFAULT_GAP_CYCLES    = 4;

    // A sample_count of zero stands for a full 65536-sample playback.
    function automatic logic [16:0] sample_total(input logic [15:0] count);
        return (count == 16'd0) ? 17'h10000 : {1'b0, count};
    endfunction

endpackage

// File: rtl/flash_pwm_sequencer_if.sv
// Control, status and SPI flash signals of the PWM sequencer, bundled
// so the sequencer (slave) and its driver (master) share one port.
interface flash_pwm_sequencer_if;
    import pwm_pkg::*;

    logic        start;
    logic        stop;
    logic        loop;
    logic [23:0] base_addr;
    logic [15:0] sample_count;
    logic        spi_cs;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso;
    logic [7:0]  duty;
    logic        duty_valid;
    logic        busy;

    modport slave (
        input  start, stop, loop, base_addr, sample_count, spi_miso,
        output spi_cs, spi_clk, spi_mosi, duty, duty_valid, busy
    );

    modport master (
        output start, stop, loop, base_addr, sample_count, spi_miso,
        input  spi_cs, spi_clk, spi_mosi, duty, duty_valid, busy
    );

endinterface

// File: rtl/spi_shifter.sv
// SPI mode-0 bit engine: each bit is one clk with spi_clk low (mosi set)
// then one clk with spi_clk high; miso is captured on the edge ending the high phase.
module spi_shifter
    import pwm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        abort_i,
    input  logic        load_i,
    input  logic [5:0]  nbits_i,
    input  logic [31:0] data_i,
    input  logic        miso_i,
    output logic        sclk_o,
    output logic        mosi_o,
    output logic        done_o,
    output logic [7:0]  rx_o
);

    logic        active_q, active_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic [31:0] sr_q, sr_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [7:0]  rx_q, rx_d;
    logic        last_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            sr_q     <= 32'h0;
            cnt_q    <= 6'd0;
            rx_q     <= 8'h0;
        end else begin
            active_q <= active_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            rx_q     <= rx_d;
        end
    end

    // A load arriving on the final high phase chains the next transfer with no idle bit.
    always_comb begin
        active_d = active_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        rx_d     = rx_q;
        last_bit = (cnt_q == 6'd0);

        if (active_q && sclk_q) begin
            rx_d = {rx_q[6:0], miso_i};
        end

        if (abort_i) begin
            active_d = 1'b0;
            sclk_d   = 1'b0;
            mosi_d   = 1'b0;
        end else if (load_i) begin
            active_d = 1'b1;
            sclk_d   = 1'b0;
            mosi_d   = data_i[31];
            sr_d     = {data_i[30:0], 1'b0};
            cnt_d    = nbits_i - 6'd1;
        end else if (active_q) begin
            if (!sclk_q) begin
                sclk_d = 1'b1;
            end else if (last_bit) begin
                active_d = 1'b0;
                sclk_d   = 1'b0;
                mosi_d   = 1'b0;
            end else begin
                sclk_d = 1'b0;
                mosi_d = sr_q[31];
                sr_d   = {sr_q[30:0], 1'b0};
                cnt_d  = cnt_q - 6'd1;
            end
        end
    end

    assign sclk_o = sclk_q;
    assign mosi_o = mosi_q;
    assign done_o = active_q && sclk_q && last_bit;
    assign rx_o   = rx_q;

endmodule

// File: rtl/flash_pwm_sequencer.sv
// Streams 8-bit PWM samples from SPI flash with one READ command per pass,
// presenting a new duty value every SAMPLE_PERIOD clocks, optionally looping.
module flash_pwm_sequencer
    import pwm_pkg::*;
#(
    parameter int SAMPLE_PERIOD = DEFAULT_SAMPLE_PERIOD,
    parameter int GAP_CYCLES    = DEFAULT_GAP_CYCLES
) (
    input logic                   clk,
    input logic                   rst_n,
    flash_pwm_sequencer_if.slave  bus
);

    localparam logic [15:0] TICK_AT  = 16'(SAMPLE_PERIOD - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    state_e      state_q, state_d;
    logic        cs_q, cs_d;
    logic [7:0]  duty_q, duty_d;
    logic        dv_q, dv_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] gap_q, gap_d;
    logic [16:0] idx_q, idx_d;
    logic [16:0] total_q, total_d;
    logic [23:0] base_q, base_d;
    logic        loop_q, loop_d;

    logic        sh_load, sh_abort, sh_done, sh_sclk, sh_mosi;
    logic [5:0]  sh_nbits;
    logic [31:0] sh_data;
    logic [7:0]  sh_rx;

    spi_shifter u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .abort_i (sh_abort),
        .load_i  (sh_load),
        .nbits_i (sh_nbits),
        .data_i  (sh_data),
        .miso_i  (bus.spi_miso),
        .sclk_o  (sh_sclk),
        .mosi_o  (sh_mosi),
        .done_o  (sh_done),
        .rx_o    (sh_rx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cs_q    <= 1'b1;
            duty_q  <= 8'h0;
            dv_q    <= 1'b0;
            timer_q <= 16'd0;
            gap_q   <= 16'd0;
            idx_q   <= 17'd0;
            total_q <= 17'd0;
            base_q  <= 24'h0;
            loop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            duty_q  <= duty_d;
            dv_q    <= dv_d;
            timer_q <= timer_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            total_q <= total_d;
            base_q  <= base_d;
            loop_q  <= loop_d;
        end
    end

    // Stop outranks every other event, including a start or a tick in the same cycle.
    always_comb begin
        state_d  = state_q;
        cs_d     = cs_q;
        duty_d   = duty_q;
        dv_d     = 1'b0;
        timer_d  = timer_q;
        gap_d    = gap_q;
        idx_d    = idx_q;
        total_d  = total_q;
        base_d   = base_q;
        loop_d   = loop_q;
        sh_load  = 1'b0;
        sh_abort = 1'b0;
        sh_nbits = 6'd32;
        sh_data  = {READ_OPCODE, base_q};

        if (state_q != ST_IDLE && bus.stop) begin
            state_d  = ST_IDLE;
            cs_d     = 1'b1;
            sh_abort = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_d = ST_CMD;
                        cs_d    = 1'b0;
                        base_d  = bus.base_addr;
                        loop_d  = bus.loop;
                        total_d = sample_total(bus.sample_count);
                        idx_d   = 17'd0;
                        sh_load = 1'b1;
                        sh_data = {READ_OPCODE, bus.base_addr};
                    end
                end
                ST_CMD: begin
                    if (sh_done) begin
                        state_d  = ST_FETCH;
                        timer_d  = 16'd0;
                        sh_load  = 1'b1;
                        sh_nbits = 6'd8;
                        sh_data  = 32'h0;
                    end
                end
                ST_FETCH: begin
                    timer_d = timer_q + 16'd1;
                    if (sh_done) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (timer_q == TICK_AT) begin
                        duty_d = sh_rx;
                        dv_d   = 1'b1;
                        idx_d  = idx_q + 17'd1;
                        if (idx_q == total_q - 17'd1) begin
                            cs_d    = 1'b1;
                            gap_d   = 16'd0;
                            state_d = loop_q ? ST_GAP : ST_IDLE;
                        end else begin
                            state_d  = ST_FETCH;
                            timer_d  = 16'd0;
                            sh_load  = 1'b1;
                            sh_nbits = 6'd8;
                            sh_data  = 32'h0;
                        end
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_d = ST_CMD;
                        cs_d    = 1'b0;
                        idx_d   = 17'd0;
                        sh_load = 1'b1;
                    end else begin
                        gap_d = gap_q + 16'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cs_d    = 1'b1;
                end
            endcase
        end
    end

    assign bus.spi_cs     = cs_q;
    assign bus.spi_clk    = sh_sclk;
    assign bus.spi_mosi   = sh_mosi;
    assign bus.duty       = duty_q;
    assign bus.duty_valid = dv_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_flash_pwm_sequencer.sv
// Self-checking bench: behavioural SPI flash model, duty scoreboard, vector
// table for plain playbacks and hand-written sequences for loop/stop/reset cases.
module tb_flash_pwm_sequencer;
    import pwm_pkg::*;

    localparam int SP    = 32;
    localparam int GAP   = 4;
    localparam int LIMIT = 6000;

    typedef struct {
        logic [23:0] base;
        logic [15:0] count;
        logic [31:0] expCmd;
    } vec_t;

    typedef struct {
        logic [7:0] duty;
        bit         first;
    } exp_t;

    typedef struct {
        logic [7:0] duty;
        int         cycle;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    flash_pwm_sequencer_if ifc();

    flash_pwm_sequencer #(.SAMPLE_PERIOD(SP), .GAP_CYCLES(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int total = 0;
    int bad   = 0;

    function automatic logic [7:0] flashByte(input logic [23:0] a);
        if (a == 24'h000400) return 8'h10;
        if (a == 24'h000401) return 8'h80;
        return a[7:0] ^ a[15:8] ^ 8'h5C;
    endfunction

    // Flash model: 32 command bits on rising spi_clk, then data bits presented on falling spi_clk.
    int          bitCnt   = 0;
    int          cmdSeen  = 0;
    int          modelK   = 0;
    logic [31:0] cmdShift = 32'h0;
    logic [31:0] lastCmd  = 32'h0;
    logic [7:0]  modelByte;

    always @(posedge ifc.spi_clk or negedge ifc.spi_clk or posedge ifc.spi_cs) begin
        if (ifc.spi_cs) begin
            bitCnt       = 0;
            ifc.spi_miso = 1'b0;
        end else if (ifc.spi_clk) begin
            if (bitCnt < 32) cmdShift = {cmdShift[30:0], ifc.spi_mosi};
            bitCnt++;
            if (bitCnt == 32) begin
                lastCmd = cmdShift;
                cmdSeen++;
            end
        end else if (bitCnt >= 32) begin
            modelK       = bitCnt - 32;
            modelByte    = flashByte(lastCmd[23:0] + 24'(modelK / 8));
            ifc.spi_miso = modelByte[7 - (modelK % 8)];
        end
    end

    obs_t obsQ[$];
    int   cycle      = 0;
    int   csHighRun  = 0;
    int   lastGapLen = 0;
    int   gapCount   = 0;

    always @(negedge clk) begin
        cycle++;
        if (ifc.duty_valid) obsQ.push_back('{duty: ifc.duty, cycle: cycle});
        if (ifc.busy && ifc.spi_cs) begin
            csHighRun++;
        end else begin
            if (ifc.busy && csHighRun > 0) begin
                lastGapLen = csHighRun;
                gapCount++;
            end
            csHighRun = 0;
        end
    end

    exp_t sbQ[$];
    int   obsIdx    = 0;
    int   prevCycle = 0;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic drainScoreboard();
        obs_t o;
        exp_t e;
        while (obsIdx < obsQ.size()) begin
            o = obsQ[obsIdx];
            obsIdx++;
            if (sbQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_duty_valid: got=%0h want=none", o.duty);
            end else begin
                e = sbQ.pop_front();
                checkVal("duty", 32'(o.duty), 32'(e.duty));
                if (!e.first) checkVal("period", 32'(o.cycle - prevCycle), 32'(SP));
            end
            prevCycle = o.cycle;
        end
    endtask

    task automatic pulseStart(input logic [23:0] base, input logic [15:0] count,
                              input logic lp, input logic withStop);
        @(posedge clk); #1;
        ifc.start        = 1'b1;
        ifc.stop         = withStop;
        ifc.base_addr    = base;
        ifc.sample_count = count;
        ifc.loop         = lp;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        ifc.stop  = 1'b0;
    endtask

    task automatic applyStimulus(input logic [23:0] base, input logic [15:0] count,
                                 input logic lp, input int passes);
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < int'(count); i++) begin
                sbQ.push_back('{duty: flashByte(base + 24'(i)), first: (i == 0)});
            end
        end
        pulseStart(base, count, lp, 1'b0);
    endtask

    task automatic pulseStop();
        ifc.stop = 1'b1;
        @(posedge clk); #1;
        ifc.stop = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (ifc.busy && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        checkVal("idle_timeout", 32'(ifc.busy), 32'd0);
    endtask

    task automatic waitBits(input int target);
        int n = 0;
        while (bitCnt != target && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        checkVal("bit_timeout", 32'(bitCnt), 32'(target));
    endtask

    task automatic waitObs(input int target);
        int n = 0;
        while (obsQ.size() < target && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        checkVal("obs_timeout", 32'(obsQ.size() >= target), 32'd1);
    endtask

    task automatic checkOutput(input vec_t v, input int cmd0, input int obs0);
        checkVal("cmd_word", lastCmd, v.expCmd);
        checkVal("cmd_count", 32'(cmdSeen - cmd0), 32'd1);
        checkVal("valid_count", 32'(obsQ.size() - obs0), 32'(v.count));
        checkVal("cs_idle", 32'(ifc.spi_cs), 32'd1);
        checkVal("sclk_idle", 32'(ifc.spi_clk), 32'd0);
        checkVal("duty_hold", 32'(ifc.duty), 32'(flashByte(v.base + 24'(v.count) - 24'd1)));
        checkVal("sb_empty", 32'(sbQ.size()), 32'd0);
    endtask

    task automatic runVector(input vec_t v);
        int cmd0 = cmdSeen;
        int obs0 = obsQ.size();
        applyStimulus(v.base, v.count, 1'b0, 1);
        waitIdle();
        @(negedge clk);
        drainScoreboard();
        checkOutput(v, cmd0, obs0);
    endtask

    initial begin
        vec_t vecs[4];
        int   cmd0;
        int   obs0;
        int   gap0;

        vecs[0] = '{base: 24'h001234, count: 16'd3, expCmd: 32'h03001234};
        vecs[1] = '{base: 24'hFFFFFE, count: 16'd3, expCmd: 32'h03FFFFFE};
        vecs[2] = '{base: 24'h000400, count: 16'd2, expCmd: 32'h03000400};
        vecs[3] = '{base: 24'hABCDEF, count: 16'd1, expCmd: 32'h03ABCDEF};

        rst_n            = 1'b0;
        ifc.start        = 1'b0;
        ifc.stop         = 1'b0;
        ifc.loop         = 1'b0;
        ifc.base_addr    = 24'h0;
        ifc.sample_count = 16'd0;
        repeat (2) @(negedge clk);
        checkVal("rst_cs", 32'(ifc.spi_cs), 32'd1);
        checkVal("rst_sclk", 32'(ifc.spi_clk), 32'd0);
        checkVal("rst_mosi", 32'(ifc.spi_mosi), 32'd0);
        checkVal("rst_duty", 32'(ifc.duty), 32'd0);
        checkVal("rst_valid", 32'(ifc.duty_valid), 32'd0);
        checkVal("rst_busy", 32'(ifc.busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) runVector(vecs[i]);

        // Looping playback: two passes, then abort during the inter-pass gap.
        gap0 = gapCount;
        obs0 = obsQ.size();
        applyStimulus(24'h000400, 16'd2, 1'b1, 2);
        waitObs(obs0 + 4);
        pulseStop();
        @(negedge clk);
        checkVal("loop_stop_busy", 32'(ifc.busy), 32'd0);
        checkVal("loop_stop_cs", 32'(ifc.spi_cs), 32'd1);
        drainScoreboard();
        checkVal("loop_gaps", 32'(gapCount - gap0), 32'd1);
        checkVal("loop_gap_len", 32'(lastGapLen), 32'(GAP));
        checkVal("loop_sb_empty", 32'(sbQ.size()), 32'd0);

        // Stop during command bit 20.
        obs0 = obsQ.size();
        pulseStart(24'h222222, 16'd3, 1'b0, 1'b0);
        waitBits(21);
        pulseStop();
        @(negedge clk);
        checkVal("stop_cs", 32'(ifc.spi_cs), 32'd1);
        checkVal("stop_busy", 32'(ifc.busy), 32'd0);
        checkVal("stop_sclk", 32'(ifc.spi_clk), 32'd0);
        checkVal("stop_duty", 32'(ifc.duty), 32'h80);
        repeat (SP * 3) @(negedge clk);
        checkVal("stop_no_valid", 32'(obsQ.size() - obs0), 32'd0);
        drainScoreboard();

        // Simultaneous start and stop from idle.
        pulseStart(24'h001234, 16'd3, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkVal("ss_busy", 32'(ifc.busy), 32'd0);
            checkVal("ss_cs", 32'(ifc.spi_cs), 32'd1);
        end

        // Asynchronous reset in the middle of the first fetch.
        obs0 = obsQ.size();
        pulseStart(24'h001234, 16'd3, 1'b0, 1'b0);
        waitBits(36);
        rst_n = 1'b0;
        #1;
        checkVal("mid_rst_cs", 32'(ifc.spi_cs), 32'd1);
        checkVal("mid_rst_duty", 32'(ifc.duty), 32'd0);
        checkVal("mid_rst_busy", 32'(ifc.busy), 32'd0);
        checkVal("mid_rst_sclk", 32'(ifc.spi_clk), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkVal("mid_rst_no_valid", 32'(obsQ.size() - obs0), 32'd0);
        drainScoreboard();
        runVector(vecs[0]);

        // Start pulsed while busy must not disturb the running playback.
        cmd0 = cmdSeen;
        obs0 = obsQ.size();
        applyStimulus(24'h000500, 16'd3, 1'b0, 1);
        waitObs(obs0 + 1);
        pulseStart(24'h777777, 16'd1, 1'b1, 1'b0);
        waitIdle();
        @(negedge clk);
        drainScoreboard();
        checkVal("busy_start_cmd", lastCmd, 32'h03000500);
        checkVal("busy_start_cmds", 32'(cmdSeen - cmd0), 32'd1);
        checkVal("busy_start_valids", 32'(obsQ.size() - obs0), 32'd3);
        checkVal("busy_start_cs", 32'(ifc.spi_cs), 32'd1);
        checkVal("busy_start_sb", 32'(sbQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
